// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 16x8 register file.
//   DATA_W / ADDR_W / DEPTH : entry width, address width, entry count
//   data_t / addr_t         : entry and address types
//   calc_parity()           : even-parity bit of an entry. Only present when
//                             REGFILE_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

`ifdef REGFILE_PARITY_EN
   // Returns the bit that gives the stored word plus this bit an even count of ones.
   function automatic logic calc_parity(input data_t d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/regfile_array.sv
// -----------------------------------------------------------------------------
// regfile_array
// Storage array for regfile_16x8. It holds the reset and write logic and
// provides an asynchronous read of the addressed entry.
//   clk, rst  : clock, asynchronous active-high reset (clears all entries)
//   wen       : write enable
//   addr      : shared read/write address
//   wdata     : write data
//   rd_data   : combinational contents of mem[addr]
//   rd_par    : stored parity bit of mem[addr]. Only present when
//               REGFILE_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module regfile_array
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef REGFILE_PARITY_EN
   output logic              rd_par,
`endif
   output logic [DATA_W-1:0] rd_data
);

   data_t mem_r [DEPTH];
`ifdef REGFILE_PARITY_EN
   logic  par_r [DEPTH];
`endif

   // Entry storage: reset clears every entry, and a write updates one entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wen) begin
         mem_r[addr] <= wdata;
      end else begin
         mem_r[addr] <= mem_r[addr];
      end
   end

`ifdef REGFILE_PARITY_EN
   // Parity storage. A cleared parity bit of 0 is consistent with a cleared word of 8'h00.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            par_r[i] <= 1'b0;
         end
      end else if (wen) begin
         par_r[addr] <= calc_parity(wdata);
      end else begin
         par_r[addr] <= par_r[addr];
      end
   end

   assign rd_par = par_r[addr];
`endif

   assign rd_data = mem_r[addr];

endmodule

// File: rtl/regfile_16x8.sv
// -----------------------------------------------------------------------------
// regfile_16x8
// A 16-entry x 8-bit register file with one write port and one read port on a
// shared address. The read is registered with a latency of 1 cycle. When a
// read and a write hit the same cycle, the write wins.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   ren / wen  : read / write enable
//   addr       : entry address
//   wdata      : write data
//   data_out   : registered read data. It holds its value between reads.
//   rd_valid   : one-cycle pulse when a read updated data_out
//   parity_err : registered parity mismatch of the last read. Only present
//                when REGFILE_PARITY_EN is defined.
// Optional feature macro: REGFILE_PARITY_EN
// -----------------------------------------------------------------------------
module regfile_16x8
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ren,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef REGFILE_PARITY_EN
   output logic              parity_err,
`endif
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid
);

   data_t rd_data_s;
   data_t data_nxt_s;
   logic  valid_nxt_s;
   data_t data_out_r;
   logic  rd_valid_r;
`ifdef REGFILE_PARITY_EN
   logic  rd_par_s;
   logic  perr_nxt_s;
   logic  perr_r;
`endif

   regfile_array u_array (
      .clk     (clk),
      .rst     (rst),
      .wen     (wen),
      .addr    (addr),
      .wdata   (wdata),
`ifdef REGFILE_PARITY_EN
      .rd_par  (rd_par_s),
`endif
      .rd_data (rd_data_s)
   );

   // Read-data select: bypass wdata on a collision, otherwise use the array. Hold the value when idle.
   always_comb begin
      data_nxt_s  = data_out_r;
      valid_nxt_s = 1'b0;
      if (ren) begin
         valid_nxt_s = 1'b1;
         if (wen) begin
            data_nxt_s = wdata;
         end else begin
            data_nxt_s = rd_data_s;
         end
      end else begin
         data_nxt_s  = data_out_r;
         valid_nxt_s = 1'b0;
      end
   end

   // Read output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_r <= {DATA_W{1'b0}};
         rd_valid_r <= 1'b0;
      end else begin
         data_out_r <= data_nxt_s;
         rd_valid_r <= valid_nxt_s;
      end
   end

`ifdef REGFILE_PARITY_EN
   // Parity check of the read word. Bypassed write data cannot mismatch, so a collision reports 0.
   always_comb begin
      perr_nxt_s = perr_r;
      if (ren) begin
         if (wen) begin
            perr_nxt_s = 1'b0;
         end else begin
            perr_nxt_s = calc_parity(rd_data_s) ^ rd_par_s;
         end
      end else begin
         perr_nxt_s = perr_r;
      end
   end

   // Parity error register. It updates together with data_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perr_r <= 1'b0;
      end else begin
         perr_r <= perr_nxt_s;
      end
   end

   assign parity_err = perr_r;
`endif

   assign data_out = data_out_r;
   assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_regfile_16x8.sv
// -----------------------------------------------------------------------------
// tb_regfile_16x8
// Self-checking bench for regfile_16x8. A reference model built from plain
// arrays tracks the memory contents and the expected outputs.
// -----------------------------------------------------------------------------
module tb_regfile_16x8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ren;
   logic       wen;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [7:0] data_out;
   logic       rd_valid;
`ifdef REGFILE_PARITY_EN
   logic       parity_err;
`endif

   int total = 0;
   int bad   = 0;

   // reference model
   logic [7:0] mem_m [16];
   logic       par_m [16];
   logic [7:0] exp_out;
   logic       exp_valid;
   logic       exp_perr;

   always #5 clk = ~clk;

   regfile_16x8 dut (
      .clk        (clk),
      .rst        (rst),
      .ren        (ren),
      .wen        (wen),
      .addr       (addr),
      .wdata      (wdata),
`ifdef REGFILE_PARITY_EN
      .parity_err (parity_err),
`endif
      .data_out   (data_out),
      .rd_valid   (rd_valid)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mem_m[i] = 8'h00;
         par_m[i] = 1'b0;
      end
      exp_out   = 8'h00;
      exp_valid = 1'b0;
      exp_perr  = 1'b0;
   endtask

   // One clock cycle: drive on negedge, update model at posedge, check #1 later
   task automatic step(input string tag, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      ren = r; wen = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      if (r) begin
         exp_valid = 1'b1;
         if (w) begin
            exp_out  = d;
            exp_perr = 1'b0;
         end else begin
            exp_out  = mem_m[a];
            exp_perr = (^mem_m[a]) != par_m[a];
         end
      end else begin
         exp_valid = 1'b0;
      end
      if (w) begin
         mem_m[a] = d;
         par_m[a] = ^d;
      end
      check_val({tag, "_data"},  {24'h0, data_out}, {24'h0, exp_out});
      check_val({tag, "_valid"}, {31'h0, rd_valid}, {31'h0, exp_valid});
`ifdef REGFILE_PARITY_EN
      check_val({tag, "_perr"},  {31'h0, parity_err}, {31'h0, exp_perr});
`endif
   endtask

   initial begin
      rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = 4'h0; wdata = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_data",  {24'h0, data_out}, 32'h0);
      check_val("rst_valid", {31'h0, rd_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // reset contents
      for (int i = 0; i < 16; i++) begin
         step("rst_rd", 1'b1, 1'b0, i[3:0], 8'h00);
         check_val("rst_rd_zero", {24'h0, data_out}, 32'h0);
      end
      step("rst_idle", 1'b0, 1'b0, 4'h0, 8'h00);
      check_val("rd_valid_pulse", {31'h0, rd_valid}, 32'h0);

      // write then read
      step("wr3", 1'b0, 1'b1, 4'h3, 8'hA5);
      step("wrF", 1'b0, 1'b1, 4'hF, 8'h5A);
      step("rd3", 1'b1, 1'b0, 4'h3, 8'h00);
      check_val("rd3_val", {24'h0, data_out}, 32'hA5);
      step("rdF", 1'b1, 1'b0, 4'hF, 8'h00);
      check_val("rdF_val", {24'h0, data_out}, 32'h5A);

      // hold
      step("hold_rd", 1'b1, 1'b0, 4'h3, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step("hold", 1'b0, 1'b1, 4'h3, 8'h11);
         check_val("hold_val", {24'h0, data_out}, 32'hA5);
         check_val("hold_vld", {31'h0, rd_valid}, 32'h0);
      end
      step("hold_after", 1'b1, 1'b0, 4'h3, 8'h00);
      check_val("hold_new", {24'h0, data_out}, 32'h11);

      // write-first collision
      step("coll", 1'b1, 1'b1, 4'h7, 8'hC3);
      check_val("coll_val", {24'h0, data_out}, 32'hC3);
      step("coll_other", 1'b1, 1'b0, 4'h0, 8'h00);
      step("coll_rd", 1'b1, 1'b0, 4'h7, 8'h00);
      check_val("coll_later", {24'h0, data_out}, 32'hC3);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom));
      end

`ifdef REGFILE_PARITY_EN
      step("par_wr", 1'b0, 1'b1, 4'h2, 8'h81);
      step("par_ok", 1'b1, 1'b0, 4'h2, 8'h00);
      check_val("par_ok_err", {31'h0, parity_err}, 32'h0);
      @(negedge clk);
      dut.u_array.mem_r[2] = dut.u_array.mem_r[2] ^ 8'h01;
      mem_m[2] = 8'h80;
      step("par_bad", 1'b1, 1'b0, 4'h2, 8'h00);
      check_val("par_bad_err", {31'h0, parity_err}, 32'h1);
`endif

      // async reset mid-operation
      for (int i = 0; i < 16; i++) begin
         step("ff_wr", 1'b0, 1'b1, i[3:0], 8'hFF);
      end
      step("ff_rd", 1'b1, 1'b0, 4'h5, 8'h00);
      check_val("ff_rd_val", {24'h0, data_out}, 32'hFF);
      ren = 1'b1; wen = 1'b1; addr = 4'h9; wdata = 8'h3C;
      #2;
      rst = 1'b1;
      #1;
      check_val("async_data",  {24'h0, data_out}, 32'h0);
      check_val("async_valid", {31'h0, rd_valid}, 32'h0);
      model_reset();
      @(negedge clk);
      ren = 1'b0; wen = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step("post_rst", 1'b1, 1'b0, i[3:0], 8'h00);
         check_val("post_rst_zero", {24'h0, data_out}, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
